// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t     : sequencer state encoding (RUN, MEM_WAIT, HALT)
//   REG_ADDR_W_DEF : default register-file index width
//   NOP_INSN       : instruction word the pipeline registers load as a bubble
// ----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_t;

   localparam int          REG_ADDR_W_DEF = 5;
   localparam logic [31:0] NOP_INSN       = 32'h0000_0013;

endpackage : hazard_pkg

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current count value
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // next count: advance only when requested and not yet saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // count register with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage RISC-V pipeline. Resolves load-use
// hazards, taken-branch redirects and data-memory waits (with a watchdog that
// halts the pipe), and keeps saturating stall/flush performance counters.
//   id_rs1/id_rs2, id_uses_rs1/2 : source operands of the instruction in ID
//   ex_mem_read, ex_rd           : load in EX and its destination
//   ex_branch_taken              : EX redirects the front end
//   dmem_req, dmem_ready         : outstanding MEM access / completes now
//   pc_en .. ex_mem_en           : register load enables
//   if_id/id_ex/mem_wb_flush     : load a bubble into that register
//   mem_err                      : sticky watchdog error (HALT)
//   stall_cnt, flush_cnt         : saturating performance counters
// Outputs are combinational from state and inputs.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_branch_taken,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  mem_wb_flush,
   output logic                  mem_err,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt
);

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_t         state_q, state_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;
   logic              mem_err_q, mem_err_d;

   logic load_use_s;
   logic stall_inc_s;
   logic flush_inc_s;

   // A taken branch kills the ID instruction, so it masks any load-use hazard.
   logic run_pc_en_s;
   logic run_if_id_flush_s;
   logic run_id_ex_flush_s;

   assign load_use_s = ex_mem_read && (ex_rd != '0) &&
                       (((ex_rd == id_rs1) && id_uses_rs1) ||
                        ((ex_rd == id_rs2) && id_uses_rs2));

   assign run_pc_en_s       = ex_branch_taken || !load_use_s;
   assign run_if_id_flush_s = ex_branch_taken;
   assign run_id_ex_flush_s = ex_branch_taken || load_use_s;

   // next-state and output decode
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      mem_err_d    = mem_err_q;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
         state_d      = RUN;
         wait_d       = '0;
         mem_err_d    = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (dmem_req && !dmem_ready) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_en    = 1'b0;
                  mem_wb_flush = 1'b1;
                  state_d      = MEM_WAIT;
                  wait_d       = WAIT_W'(1);
               end else begin
                  pc_en       = run_pc_en_s;
                  if_id_en    = run_pc_en_s;
                  if_id_flush = run_if_id_flush_s;
                  id_ex_flush = run_id_ex_flush_s;
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  // release in the ready cycle; pending redirect/hazard served now
                  pc_en       = run_pc_en_s;
                  if_id_en    = run_pc_en_s;
                  if_id_flush = run_if_id_flush_s;
                  id_ex_flush = run_id_ex_flush_s;
                  state_d     = RUN;
                  wait_d      = '0;
               end else begin
                  pc_en     = 1'b0;
                  if_id_en  = 1'b0;
                  id_ex_en  = 1'b0;
                  ex_mem_en = 1'b0;
                  if (wait_q == WAIT_LAST) begin
                     state_d   = HALT;
                     mem_err_d = 1'b1;
                  end else begin
                     wait_d = wait_q + WAIT_W'(1);
                  end
               end
            end
            HALT: begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               mem_err_d = 1'b1;
            end
            default: begin
               // unreachable encoding: stop the pipe and flag it
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               state_d   = HALT;
               mem_err_d = 1'b1;
            end
         endcase
      end
   end

   // state, wait counter and error flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err     = mem_err_q;
   assign stall_inc_s = !rst && ((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_en;
   assign flush_inc_s = !rst && if_id_flush;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc_s),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc_s),
      .count (flush_cnt)
   );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two controller instances share one stimulus stream: one with default
// parameters, one with MEM_TIMEOUT=4 and CNT_WIDTH=3. Each is compared every
// cycle against a cycle-count model of the sequencing rules.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic       dmem_req, dmem_ready;

   logic        a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fmemwb, a_err;
   logic [31:0] a_stall, a_flush;
   logic        b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fmemwb, b_err;
   logic [2:0]  b_stall, b_flush;

   int tests_run = 0;
   int tests_failed = 0;

   // model state: consecutive not-ready cycles of the current access, halted flag, counts
   int     miss_len [2];
   bit     halted   [2];
   longint stall_m  [2];
   longint flush_m  [2];
   int     tmo      [2];
   longint cmax     [2];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl u_dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(a_pc), .if_id_en(a_ifid), .id_ex_en(a_idex), .ex_mem_en(a_exmem),
      .if_id_flush(a_fifid), .id_ex_flush(a_fidex), .mem_wb_flush(a_fmemwb),
      .mem_err(a_err), .stall_cnt(a_stall), .flush_cnt(a_flush)
   );

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(3)) u_dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(b_pc), .if_id_en(b_ifid), .id_ex_en(b_idex), .ex_mem_en(b_exmem),
      .if_id_flush(b_fifid), .id_ex_flush(b_fidex), .mem_wb_flush(b_fmemwb),
      .mem_err(b_err), .stall_cnt(b_stall), .flush_cnt(b_flush)
   );

   task automatic chk(input string tag, input longint act, input longint exp);
      tests_run++;
      assert (act === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // expected {pc,if_id,id_ex,ex_mem enables, if_id,id_ex,mem_wb flushes}
   function automatic logic [6:0] expect_ctl(input int k);
      bit hazard;
      hazard = ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1 && id_uses_rs1) || (ex_rd == id_rs2 && id_uses_rs2));
      if (rst)                                        return 7'b0000_111;
      if (halted[k])                                  return 7'b0000_000;
      if (miss_len[k] == 0 && dmem_req && !dmem_ready) return 7'b0000_001;
      if (miss_len[k] > 0 && !dmem_ready)             return 7'b0000_000;
      if (ex_branch_taken)                            return 7'b1111_110;
      if (hazard)                                     return 7'b0011_010;
      return 7'b1111_000;
   endfunction

   task automatic reset_model();
      for (int k = 0; k < 2; k++) begin
         miss_len[k] = 0;
         halted[k]   = 1'b0;
         stall_m[k]  = 0;
         flush_m[k]  = 0;
      end
   endtask

   // one clock: check at negedge, advance model at posedge
   task automatic step();
      logic [6:0] e [2];
      logic [6:0] act;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         e[k] = expect_ctl(k);
         if (k == 0) begin
            act = {a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fmemwb};
            chk("a_ctl", longint'(act), longint'(e[k]));
            chk("a_mem_err", longint'(a_err), longint'(halted[k]));
            chk("a_stall_cnt", longint'(a_stall), stall_m[k]);
            chk("a_flush_cnt", longint'(a_flush), flush_m[k]);
         end else begin
            act = {b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fmemwb};
            chk("b_ctl", longint'(act), longint'(e[k]));
            chk("b_mem_err", longint'(b_err), longint'(halted[k]));
            chk("b_stall_cnt", longint'(b_stall), stall_m[k]);
            chk("b_flush_cnt", longint'(b_flush), flush_m[k]);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            miss_len[k] = 0;
            halted[k]   = 1'b0;
            stall_m[k]  = 0;
            flush_m[k]  = 0;
         end else if (!halted[k]) begin
            if (!e[k][6] && stall_m[k] < cmax[k]) stall_m[k]++;
            if (e[k][2] && flush_m[k] < cmax[k])  flush_m[k]++;
            if ((miss_len[k] > 0 || dmem_req) && !dmem_ready) begin
               miss_len[k]++;
               if (miss_len[k] == tmo[k]) halted[k] = 1'b1;
            end else begin
               miss_len[k] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      tmo[0] = 64; cmax[0] = longint'(32'hFFFF_FFFF);
      tmo[1] = 4;  cmax[1] = 64'd7;
      reset_model();
      idle_inputs();
      rst = 1'b1;
      #1;
      // reset outputs held while rst is high
      step();
      step();
      rst = 1'b0;
      step();

      // load-use on rs1, then non-hazard variants
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
      step();
      idle_inputs();
      step();
      chk("lu_stall_cnt", longint'(a_stall), 64'd1);
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
      step();
      ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
      step();
      id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
      step();

      // branch masks a matching load-use
      idle_inputs();
      do_reset();
      ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      step();
      idle_inputs();
      step();
      chk("br_flush_cnt", longint'(a_flush), 64'd1);
      chk("br_stall_cnt", longint'(a_stall), 64'd0);

      // 3-cycle memory wait, then release
      do_reset();
      dmem_req = 1'b1;
      repeat (3) step();
      dmem_ready = 1'b1;
      step();
      idle_inputs();
      step();
      chk("mw_stall_cnt", longint'(a_stall), 64'd3);

      // branch pending during wait is serviced on the ready cycle
      dmem_req = 1'b1; ex_branch_taken = 1'b1;
      repeat (2) step();
      dmem_ready = 1'b1;
      step();
      idle_inputs();
      step();

      // watchdog: instance b halts after 4, instance a after 64
      do_reset();
      dmem_req = 1'b1;
      repeat (6) step();
      chk("wd_b_mem_err", longint'(b_err), 64'd1);
      chk("wd_a_mem_err", longint'(a_err), 64'd0);
      repeat (60) step();
      chk("wd_a_mem_err_late", longint'(a_err), 64'd1);
      idle_inputs();
      do_reset();
      step();
      chk("wd_cleared", longint'(b_err), 64'd0);

      // rst on the 2nd MEM_WAIT cycle
      dmem_req = 1'b1;
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      step();
      chk("rmw_stall_cnt", longint'(a_stall), 64'd0);

      // 10 consecutive load-use stalls saturate the 3-bit counter
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
      repeat (10) step();
      idle_inputs();
      step();
      chk("sat_b_stall", longint'(b_stall), 64'd7);
      chk("sat_a_stall", longint'(a_stall), 64'd10);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst             = ($urandom_range(0, 39) == 0);
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         ex_rd           = 5'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom_range(0, 1));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         ex_mem_read     = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         dmem_req        = ($urandom_range(0, 3) == 0);
         dmem_ready      = 1'($urandom_range(0, 1));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pipeline_hazard_ctrl
